// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin CPU/echo byte arbiter, TX FIFO and UART start/handshake sequencer
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cpu_wr_i,
    input  logic [7:0]    cpu_data_i,
    input  logic          echo_en_i,
    input  logic          rx_done_i,
    input  logic [7:0]    rx_data_i,
    input  logic          tx_status_i,
    output logic [7:0]    tx_data_o,
    output logic          tx_start_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          busy_o,
    output logic          drop_o,
    input  logic          drop_clr_i
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            rr_q, rr_d;
    logic            drop_q, drop_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, empty_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [DEPTH];

    logic            cpu_req, echo_req, pop, drop_set;
    logic [AW:0]     free;
    logic [1:0]      n_req, n_push;
    logic [7:0]      first_data, second_data;

    // A pop in this cycle frees a slot for this cycle's pushes.
    always_comb begin
        cpu_req     = cpu_wr_i;
        echo_req    = rx_done_i & echo_en_i;
        pop         = (state_q == S_IDLE) & ~empty_q & tx_status_i;
        free        = (AW+1)'(DEPTH) - count_q + (AW+1)'(pop);
        first_data  = cpu_data_i;
        second_data = rx_data_i;
        n_req       = 2'd0;
        if (cpu_req && echo_req) begin
            n_req       = 2'd2;
            first_data  = rr_q ? rx_data_i  : cpu_data_i;
            second_data = rr_q ? cpu_data_i : rx_data_i;
        end else if (cpu_req) begin
            n_req = 2'd1;
        end else if (echo_req) begin
            n_req      = 2'd1;
            first_data = rx_data_i;
        end
        n_push = n_req;
        if (free < (AW+1)'(n_req)) begin
            n_push = free[1:0];
        end
        drop_set  = (n_push != n_req);
        count_d   = count_q + (AW+1)'(n_push) - (AW+1)'(pop);
        wr_ptr_nx = wr_ptr_q + AW'(1);
        wr_ptr_d  = wr_ptr_q + AW'(n_push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        rr_d      = (cpu_req && echo_req) ? ~rr_q : rr_q;
        drop_d    = drop_set ? 1'b1 : (drop_clr_i ? 1'b0 : drop_q);
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
                tmo_d   = '0;
            end
            // tmo_q counts WAIT_BUSY cycles already spent; leave after TIMEOUT of them.
            S_WAIT_BUSY: begin
                if (!tx_status_i) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_status_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            tx_data_q <= 8'h00;
            rr_q      <= 1'b0;
            drop_q    <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            tx_data_q <= tx_data_d;
            rr_q      <= rr_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            full_q    <= (count_d == (AW+1)'(DEPTH));
            empty_q   <= (count_d == '0);
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (n_push != 2'd0) begin
            mem_q[wr_ptr_q] <= first_data;
        end
        if (n_push == 2'd2) begin
            mem_q[wr_ptr_nx] <= second_data;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = (state_q == S_START);
    assign busy_o     = (state_q != S_IDLE);
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign drop_o     = drop_q;
endmodule
